mac_seq_ctrl: RTL and testbench
===============================

# mac_seq_ctrl

Multi-cycle sequencer for `MAC_TYPE` (opcode `5'b11111`) instructions. It sits beside the execute stage and owns a 32-bit architectural accumulator. It runs an iterative shift-add multiply, then accumulates, and stalls the pipeline until the result is ready. Non-MAC instructions pass through EX untouched; this block ignores them.

## Interface
- `XLEN`, 32: operand, accumulator and result width; also the number of multiply iterations.
- `MAC_OPCODE`, 5'b11111: instruction type this block accepts.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid_i` in 1: instruction presented by EX.
- `inst_type_i` in 5: decoded opcode.
- `inst_i` in 32: raw instruction; funct3 = `inst_i[14:12]`.
- `operand_a_i` in XLEN: rs1 value (multiplicand).
- `operand_b_i` in XLEN: rs2 value (multiplier).
- `flush_i` in 1: synchronous abort of the in-flight operation.
- `ready_o` out 1: high only in IDLE.
- `stall_o` out 1: freeze the upstream pipeline.
- `result_valid_o` out 1: one-cycle pulse carrying the result.
- `result_o` out XLEN: result; holds its last value otherwise.
- `inst_o` out 32: instruction associated with `result_o`.
- `acc_o` out XLEN: current accumulator.

## Operation
- Accept condition: `valid_i & ready_o & (inst_type_i == MAC_OPCODE)`. All other `valid_i` are ignored and `stall_o` stays 0.
- On accept, latch A, B, and inst; clear the product register.
- funct3 decoding:
  - 000 MAC: acc ← acc + lo32(A×B).
  - 001 MUL: acc ← lo32(A×B).
  - 010 CLR: acc ← 0, result 0.
  - 011 and all others RD: result = acc, acc unchanged.
- States and transitions:
  - IDLE: MAC/MUL → MUL state; CLR/RD → DONE.
  - MUL: each cycle, if `mplr[0]` then prod += mcand; mcand <<= 1; mplr >>= 1; cnt++. After XLEN cycles (cnt == XLEN-1) → ACC.
  - ACC: update acc per funct3 → DONE.
  - DONE: `result_valid_o` = 1, `result_o` = new acc (0 for CLR) → IDLE.
- Arithmetic: product is truncated to XLEN bits, so the signed/unsigned distinction is irrelevant. The add is modulo 2^XLEN unless saturation is enabled (see Configuration).
- `stall_o` = (accept & funct3 ∈ {MAC, MUL}) | state ∈ {MUL, ACC}. It is low in DONE so the pipeline captures the result that cycle.
- `flush_i`: from any non-IDLE state, go to IDLE next cycle. No `result_valid_o`, acc unchanged. On a same-cycle accept, flush wins and nothing is accepted.
- Reset (async, any state): state = IDLE, acc = 0, and all outputs are 0 except `ready_o` = 1.

## Timing
- MAC/MUL: accept at edge E0; MUL occupies cycles 1–32, ACC cycle 33, DONE cycle 34 (`result_valid_o` high). `ready_o` returns in cycle 35.
- CLR/RD: DONE in cycle 1; `ready_o` returns in cycle 2.
- `acc_o` updates on the ACC→DONE edge (CLR: the IDLE→DONE edge).
- Back-to-back MACs: the minimum issue interval is 35 cycles.

## Configuration
- `MAC_SAT_EN` defined: the MAC add saturates on signed overflow.
  - Positive overflow → 0x7FFFFFFF.
  - Negative overflow → 0x80000000.
  - MUL/CLR/RD are unaffected.
- `MAC_SAT_EN` undefined: the add wraps.

## Structure
- Shared package `mac_pkg`:
  - `MAC_OPCODE`.
  - funct3 constants `F3_MAC`, `F3_MUL`, `F3_CLR`, `F3_RD`.
  - State enum `{IDLE, MUL, ACC, DONE}`.
- One sub-module, `mac_iter_mul`: the shift-add datapath (mcand, mplr, prod, cnt), with `start`/`done` handshake. The top level holds the FSM, accumulator, saturation logic and outputs.

## Test plan
- Reset, then MAC A=3, B=5 → `stall_o` high in cycles 0–33; `result_valid_o` in cycle 34 with `result_o` = 15, `acc_o` = 15.
- Then MAC A=0xFFFFFFFF, B=2 → product 0xFFFFFFFE; `result_o` = 0x0000000D. Then CLR → result 0 in cycle 1, `acc_o` = 0.
- MUL to set acc = 0x7FFFFFF0, then MAC A=0x10, B=1 → 0x7FFFFFFF with `MAC_SAT_EN`, 0x80000000 without.
- `flush_i` in MUL cycle 10 → IDLE next cycle, no `result_valid_o`, `acc_o` unchanged, `ready_o` = 1.
- `rst_n` dropped in MUL cycle 20 → immediately IDLE; `acc_o` = 0, `stall_o` = 0.
- `valid_i` with `inst_type_i` = 5'b01100 → no accept; `stall_o`, `result_valid_o` = 0; acc unchanged.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the MAC sequencer.
package mac_pkg;

  localparam logic [4:0] MAC_OPCODE = 5'b11111;

  localparam logic [2:0] F3_MAC = 3'b000;
  localparam logic [2:0] F3_MUL = 3'b001;
  localparam logic [2:0] F3_CLR = 3'b010;
  localparam logic [2:0] F3_RD  = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ACC,
    DONE
  } state_e;

endpackage

// File: rtl/mac_iter_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low XLEN bits of the product kept.
module mac_iter_mul #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] prod_o
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplr;
  logic [XLEN-1:0] r_prod;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            w_last;

  assign w_last = (r_cnt == CW'(XLEN - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (abort_i) begin
      r_busy <= 1'b0;
    end else if (start_i) begin
      r_mcand <= a_i;
      r_mplr  <= b_i;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      if (r_mplr[0]) r_prod <= r_prod + r_mcand;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) r_busy <= 1'b0;
    end
  end

  // Asserted during the final iteration; the product is complete after this edge.
  assign done_o = r_busy & w_last;
  assign prod_o = r_prod;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Multi-cycle MAC/MUL/CLR/RD sequencer owning the architectural accumulator.
// Define MAC_SAT_EN to make the MAC accumulate saturate on signed overflow.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [4:0]      inst_type_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            stall_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] acc_o
);

  state_e          r_state;
  state_e          w_next;
  logic [2:0]      r_f3;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_result;
  logic [31:0]     r_inst_o;

  logic [2:0]      w_f3_in;
  logic            w_accept;
  logic            w_f3_is_mul;
  logic            w_mul_done;
  logic [XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_mac_val;
  logic [XLEN-1:0] w_acc_new;

  assign w_f3_in     = inst_i[14:12];
  assign w_f3_is_mul = (w_f3_in == F3_MAC) || (w_f3_in == F3_MUL);
  // A flush in the same cycle blocks the accept.
  assign w_accept    = valid_i & (r_state == IDLE) & (inst_type_i == MAC_OPCODE) & ~flush_i;

  mac_iter_mul #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (w_accept & w_f3_is_mul),
    .abort_i (flush_i),
    .a_i     (operand_a_i),
    .b_i     (operand_b_i),
    .done_o  (w_mul_done),
    .prod_o  (w_prod)
  );

  assign w_sum = r_acc + w_prod;

`ifdef MAC_SAT_EN
  logic w_ovf;
  assign w_ovf     = (r_acc[XLEN-1] == w_prod[XLEN-1]) && (w_sum[XLEN-1] != r_acc[XLEN-1]);
  assign w_mac_val = !w_ovf          ? w_sum :
                     r_acc[XLEN-1]   ? {1'b1, {(XLEN-1){1'b0}}} :
                                       {1'b0, {(XLEN-1){1'b1}}};
`else
  assign w_mac_val = w_sum;
`endif

  assign w_acc_new = (r_f3 == F3_MUL) ? w_prod : w_mac_val;

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = w_f3_is_mul ? MUL : DONE;
      MUL:  if (flush_i) w_next = IDLE; else if (w_mul_done) w_next = ACC;
      ACC:  w_next = flush_i ? IDLE : DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_f3     <= '0;
      r_inst   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_inst_o <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_f3   <= w_f3_in;
        r_inst <= inst_i;
        if (!w_f3_is_mul) begin
          r_inst_o <= inst_i;
          if (w_f3_in == F3_CLR) begin
            r_acc    <= '0;
            r_result <= '0;
          end else begin
            r_result <= r_acc;
          end
        end
      end
      if (r_state == ACC && !flush_i) begin
        r_acc    <= w_acc_new;
        r_result <= w_acc_new;
        r_inst_o <= r_inst;
      end
    end
  end

  assign ready_o        = (r_state == IDLE);
  assign stall_o        = (w_accept & w_f3_is_mul) | (r_state == MUL) | (r_state == ACC);
  assign result_valid_o = (r_state == DONE);
  assign result_o       = r_result;
  assign inst_o         = r_inst_o;
  assign acc_o          = r_acc;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: vector table with a result scoreboard plus corner-case sequences.
module tb_mac_seq_ctrl;
  import mac_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [4:0]  inst_type_i;
  logic [31:0] inst_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        flush_i;
  logic        ready_o;
  logic        stall_o;
  logic        result_valid_o;
  logic [31:0] result_o;
  logic [31:0] inst_o;
  logic [31:0] acc_o;

  mac_seq_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (valid_i),
    .inst_type_i    (inst_type_i),
    .inst_i         (inst_i),
    .operand_a_i    (operand_a_i),
    .operand_b_i    (operand_b_i),
    .flush_i        (flush_i),
    .ready_o        (ready_o),
    .stall_o        (stall_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .inst_o         (inst_o),
    .acc_o          (acc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] acc;
    logic [31:0] inst;
  } exp_t;

`ifdef MAC_SAT_EN
  localparam logic [31:0] POS_OVF = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_OVF = 32'h8000_0000;
`else
  localparam logic [31:0] POS_OVF = 32'h8000_0000;
  localparam logic [31:0] NEG_OVF = 32'h7FFF_FFFF;
`endif

  vec_t        vecs[12];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_acc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [7:0] tag);
    return {tag, 9'h0, f3, 5'h0, 7'h33};
  endfunction

  // Issue one MAC-type op and follow it to its result pulse.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic [7:0] tag);
    logic [31:0] inst;
    int          lat;
    int          exp_lat;
    bit          stall_ok;
    bit          is_mul;
    exp_t        e;
    inst    = mk_inst(f3, tag);
    is_mul  = (f3 == F3_MAC) || (f3 == F3_MUL);
    exp_lat = is_mul ? 34 : 1;
    sb.push_back('{res: exp_res, acc: exp_res, inst: inst});
    @(negedge clk);
    valid_i = 1'b1; inst_type_i = MAC_OPCODE; inst_i = inst;
    operand_a_i = a; operand_b_i = b;
    #1;
    check({name, ".stall_accept"}, 32'(stall_o), 32'(is_mul));
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0; operand_a_i = $urandom; operand_b_i = $urandom; inst_i = $urandom;
    lat = 0; stall_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      #1;
      if (result_valid_o) begin lat = c; break; end
      if (!stall_o) stall_ok = 1'b0;
      @(negedge clk);
    end
    check({name, ".latency"}, 32'(lat), 32'(exp_lat));
    if (is_mul) check({name, ".stall_busy"}, 32'(stall_ok), 32'd1);
    e = sb.pop_front();
    if (lat != 0) begin
      check({name, ".result"}, result_o, e.res);
      check({name, ".acc"}, acc_o, e.acc);
      check({name, ".inst"}, inst_o, e.inst);
      check({name, ".stall_done"}, 32'(stall_o), 32'd0);
      @(negedge clk); #1;
      check({name, ".ready_after"}, 32'(ready_o), 32'd1);
    end
    model_acc = exp_res;
  endtask

  // Watch a window of cycles and count any unexpected result pulse.
  task automatic expect_quiet(input string name, input int cycles);
    int pulses;
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk); #1;
      if (result_valid_o) pulses++;
    end
    check({name, ".no_result"}, 32'(pulses), 32'd0);
    check({name, ".acc_kept"}, acc_o, model_acc);
    check({name, ".ready"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{F3_MAC, 32'd3,          32'd5,          32'h0000_000F};
    vecs[1]  = '{F3_MAC, 32'hFFFF_FFFF,  32'd2,          32'h0000_000D};
    vecs[2]  = '{F3_CLR, 32'h1234_5678,  32'h9ABC_DEF0,  32'h0000_0000};
    vecs[3]  = '{F3_RD,  32'd0,          32'd0,          32'h0000_0000};
    vecs[4]  = '{F3_MUL, 32'h7FFF_FFF0,  32'd1,          32'h7FFF_FFF0};
    vecs[5]  = '{F3_MAC, 32'h0000_0010,  32'd1,          POS_OVF};
    vecs[6]  = '{F3_RD,  32'hDEAD_BEEF,  32'h1,          POS_OVF};
    vecs[7]  = '{F3_MUL, 32'h1234_5678,  32'h10,         32'h2345_6780};
    vecs[8]  = '{F3_MAC, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h2345_6781};
    vecs[9]  = '{F3_MUL, 32'h0000_FFFF,  32'h0001_0001,  32'hFFFF_FFFF};
    vecs[10] = '{F3_MAC, 32'h8000_0000,  32'd1,          NEG_OVF};
    vecs[11] = '{3'b111, 32'h0,          32'h0,          NEG_OVF};

    rst_n = 1'b0; valid_i = 1'b0; inst_type_i = '0; inst_i = '0;
    operand_a_i = '0; operand_b_i = '0; flush_i = 1'b0;
    #1;
    check("reset.ready", 32'(ready_o), 32'd1);
    check("reset.stall", 32'(stall_o), 32'd0);
    check("reset.result_valid", 32'(result_valid_o), 32'd0);
    check("reset.result", result_o, 32'd0);
    check("reset.inst", inst_o, 32'd0);
    check("reset.acc", acc_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 8'(i + 1));

    // Flush during MUL cycle 10.
    @(negedge clk);
    valid_i = 1'b1; inst_type_i = MAC_OPCODE; inst_i = mk_inst(F3_MAC, 8'hA0);
    operand_a_i = 32'd7; operand_b_i = 32'd9;
    @(posedge clk);
    @(negedge clk); valid_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk); flush_i = 1'b0; #1;
    check("flush.ready_next", 32'(ready_o), 32'd1);
    check("flush.stall_next", 32'(stall_o), 32'd0);
    expect_quiet("flush", 40);

    // Flush coincident with an accept in IDLE.
    @(negedge clk);
    valid_i = 1'b1; inst_type_i = MAC_OPCODE; inst_i = mk_inst(F3_MAC, 8'hA1);
    operand_a_i = 32'd2; operand_b_i = 32'd2; flush_i = 1'b1;
    #1;
    check("flush_accept.stall", 32'(stall_o), 32'd0);
    @(negedge clk); valid_i = 1'b0; flush_i = 1'b0;
    expect_quiet("flush_accept", 40);

    // Non-MAC opcode is ignored.
    @(negedge clk);
    valid_i = 1'b1; inst_type_i = 5'b01100; inst_i = mk_inst(F3_MAC, 8'hA2);
    operand_a_i = 32'd4; operand_b_i = 32'd4;
    #1;
    check("non_mac.stall", 32'(stall_o), 32'd0);
    @(negedge clk); valid_i = 1'b0;
    expect_quiet("non_mac", 40);

    // Reset asserted during MUL cycle 20.
    @(negedge clk);
    valid_i = 1'b1; inst_type_i = MAC_OPCODE; inst_i = mk_inst(F3_MAC, 8'hA3);
    operand_a_i = 32'd11; operand_b_i = 32'd13;
    @(posedge clk);
    @(negedge clk); valid_i = 1'b0;
    repeat (19) @(negedge clk);
    #1;
    check("midrst.stall_before", 32'(stall_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.ready", 32'(ready_o), 32'd1);
    check("midrst.stall", 32'(stall_o), 32'd0);
    check("midrst.acc", acc_o, 32'd0);
    check("midrst.result_valid", 32'(result_valid_o), 32'd0);
    check("midrst.result", result_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    model_acc = '0;
    expect_quiet("midrst", 40);

    run_op("post_rst", F3_MAC, 32'd3, 32'd5, 32'h0000_000F, 8'hB0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
